// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit type encoding, flit type field
// position, router port indices and the output-port arbiter state type.
package noc_pkg;

  typedef enum logic [1:0] {
    HEAD      = 2'b00,
    BODY      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_t;

  localparam int FLIT_TYPE_MSB = 33;
  localparam int FLIT_TYPE_LSB = 32;

  localparam int LOCAL = 0;
  localparam int NORTH = 1;
  localparam int SOUTH = 2;
  localparam int WEST  = 3;
  localparam int EAST  = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // A flit that may open a packet.
  function automatic logic is_head(input flit_type_t t);
    return (t == HEAD) || (t == HEAD_TAIL);
  endfunction

  // A flit that closes a packet.
  function automatic logic is_tail(input flit_type_t t);
    return (t == TAIL) || (t == HEAD_TAIL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Picks the first asserted request at or
// after the pointer, wrapping from N-1 to 0.
//   req_i   : request vector
//   ptr_i   : highest-priority index
//   gnt_o   : one-hot grant (zero when no request)
//   idx_o   : binary index of the granted request
//   found_o : at least one request was asserted
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= N) s = s - N;
    return s;
  endfunction

  always_comb begin
    logic [IW-1:0] j;
    j       = '0;
    gnt_o   = '0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = IW'(wrap_idx(int'(ptr_i), k));
      if (!found_o && req_i[j]) begin
        found_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Wormhole output-port arbiter: grants one router output to one input per
// packet with round-robin fairness and forwards flits with valid/ready.
//   clk, arst : clock, asynchronous active-low reset
//   req_i     : per-input request for this output
//   valid_i   : per-input flit valid
//   flit_i    : per-input flits, input 0 in the LSBs
//   ready_o   : per-input ready (only the owner sees ready_i)
//   flit_o    : forwarded flit, valid_o : forwarded valid
//   ready_i   : downstream ready
//   grant_o   : one-hot owner, zero when idle
//   busy_o    : locked to a packet
//   err_o     : sticky, a head flit arrived inside a packet
//
// state      | meaning
// ARB_IDLE   | no owner; arbitrate among head-flit candidates
// ARB_LOCKED | owner fixed until its tail flit transfers
module output_port_arbiter
  import noc_pkg::*;
#(
  parameter int N_INPUTS   = 5,
  parameter int FLIT_WIDTH = 34
) (
  input  logic                           clk,
  input  logic                           arst,
  input  logic [N_INPUTS-1:0]            req_i,
  input  logic [N_INPUTS-1:0]            valid_i,
  input  logic [N_INPUTS*FLIT_WIDTH-1:0] flit_i,
  output logic [N_INPUTS-1:0]            ready_o,
  output logic [FLIT_WIDTH-1:0]          flit_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [N_INPUTS-1:0]            grant_o,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         gidx_q, gidx_d;
  logic [N_INPUTS-1:0]   grant_q, grant_d;
  logic [IW-1:0]         rr_q, rr_d;
  logic                  err_q, err_d;
  logic                  first_q, first_d;

  logic [N_INPUTS-1:0]   cand;
  logic [N_INPUTS-1:0]   arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  arb_found;
  logic [FLIT_WIDTH-1:0] sel_flit;
  logic                  sel_valid;
  flit_type_t            sel_type;

  always_comb begin
    cand = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      cand[i] = req_i[i] & valid_i[i] &
                is_head(flit_type_t'(flit_i[i*FLIT_WIDTH+FLIT_TYPE_LSB +: 2]));
    end
  end

  rr_arbiter #(.N(N_INPUTS), .IW(IW)) u_rr (
    .req_i   (cand),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .found_o (arb_found)
  );

  always_comb begin
    sel_flit  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (gidx_q == IW'(i)) begin
        sel_flit  = flit_i[i*FLIT_WIDTH +: FLIT_WIDTH];
        sel_valid = valid_i[i];
      end
    end
  end

  assign sel_type = flit_type_t'(sel_flit[FLIT_TYPE_MSB:FLIT_TYPE_LSB]);

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    err_d   = err_q;
    first_d = first_q;
    flit_o  = '0;
    valid_o = 1'b0;
    ready_o = '0;
    grant_o = '0;
    busy_o  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (arb_found) begin
          state_d = ARB_LOCKED;
          gidx_d  = arb_idx;
          grant_d = arb_gnt;
          first_d = 1'b1;
        end
      end
      ARB_LOCKED: begin
        busy_o  = 1'b1;
        grant_o = grant_q;
        flit_o  = sel_flit;
        valid_o = sel_valid;
        ready_o = grant_q & {N_INPUTS{ready_i}};
        if (sel_valid && ready_i) begin
          first_d = 1'b0;
          // A head after the packet's first flit is a protocol error; the
          // flit is still forwarded and the lock is kept unless it is a tail.
          if (is_head(sel_type) && !first_q) err_d = 1'b1;
          if (is_tail(sel_type)) begin
            state_d = ARB_IDLE;
            grant_d = '0;
            // Pointer moves only on packet completion, past the finished owner.
            rr_d    = (gidx_q == IW'(N_INPUTS-1)) ? '0 : gidx_q + IW'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q <= ARB_IDLE;
      gidx_q  <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
module tb_output_port_arbiter;

  localparam int N = 5;
  localparam int W = 34;
  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  logic           clk = 1'b0;
  logic           arst;
  logic [N-1:0]   req_i, valid_i, ready_o, grant_o;
  logic [N*W-1:0] flit_i;
  logic [W-1:0]   flit_o;
  logic           valid_o, ready_i, busy_o, err_o;

  output_port_arbiter #(.N_INPUTS(N), .FLIT_WIDTH(W)) dut (
    .clk(clk), .arst(arst), .req_i(req_i), .valid_i(valid_i), .flit_i(flit_i),
    .ready_o(ready_o), .flit_o(flit_o), .valid_o(valid_o), .ready_i(ready_i),
    .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int src; logic [W-1:0] flit; } xfer_t;
  xfer_t sb[$];

  int   m_owner, m_rr, n_owner, n_rr, xfer_src;
  bit   m_first, n_first, m_err, n_err;
  logic [N-1:0] exp_grant, exp_ready;
  logic         exp_valid, exp_busy, exp_err;
  logic [W-1:0] exp_flit;

  function automatic logic [W-1:0] mk(input logic [1:0] t, input int src, input int seq);
    return {t, 8'(src), 24'(seq)};
  endfunction

  function automatic logic [N*W-1:0] put(input logic [N*W-1:0] vec, input int i, input logic [W-1:0] fl);
    vec[i*W +: W] = fl;
    return vec;
  endfunction

  function automatic bit opens(input logic [1:0] t);
    return (t == T_HEAD) || (t == T_HT);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_first = 0; m_err = 0;
    n_owner = -1; n_rr = 0; n_first = 0; n_err = 0;
    xfer_src = -1;
    sb.delete();
  endtask

  task automatic model_eval();
    logic [W-1:0] fl;
    int w;
    n_owner = m_owner; n_rr = m_rr; n_first = m_first; n_err = m_err;
    xfer_src  = -1;
    exp_grant = '0; exp_ready = '0; exp_valid = 1'b0; exp_busy = 1'b0;
    exp_flit  = '0; exp_err = m_err;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        w  = (m_rr + k) % N;
        fl = flit_i[w*W +: W];
        if (n_owner < 0 && req_i[w] && valid_i[w] && opens(fl[W-1:W-2])) n_owner = w;
      end
      n_first = 1;
    end else begin
      fl = flit_i[m_owner*W +: W];
      exp_busy = 1'b1;
      exp_grant[m_owner] = 1'b1;
      exp_valid = valid_i[m_owner];
      exp_flit  = fl;
      exp_ready[m_owner] = ready_i;
      if (exp_valid && ready_i) begin
        sb.push_back('{m_owner, fl});
        xfer_src = m_owner;
        if (opens(fl[W-1:W-2]) && !m_first) n_err = 1;
        n_first = 0;
        if (fl[W-1:W-2] == T_TAIL || fl[W-1:W-2] == T_HT) begin
          n_owner = -1;
          n_rr = (m_owner + 1) % N;
        end
      end
    end
  endtask

  task automatic model_commit();
    m_owner = n_owner; m_rr = n_rr; m_first = n_first; m_err = n_err;
  endtask

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0;
  bit mon_en = 0;
  logic [N-1:0] h_grant[$];
  logic [W-1:0] h_flit[$];
  bit h_busy[$], h_xfer[$], h_valid[$], h_err[$];

  always @(negedge clk) begin
    xfer_t e;
    if (mon_en) begin
      chk("grant_o", 64'(grant_o), 64'(exp_grant));
      chk("busy_o",  64'(busy_o),  64'(exp_busy));
      chk("valid_o", 64'(valid_o), 64'(exp_valid));
      chk("ready_o", 64'(ready_o), 64'(exp_ready));
      chk("err_o",   64'(err_o),   64'(exp_err));
      if (exp_valid) chk("flit_o", 64'(flit_o), 64'(exp_flit));
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_xfer: got flit %0h expected no transfer", flit_o);
        end else begin
          e = sb.pop_front();
          chk("xfer_src",  64'(grant_o), 64'(1) << e.src);
          chk("xfer_flit", 64'(flit_o),  64'(e.flit));
        end
      end
      h_grant.push_back(grant_o);
      h_flit.push_back(flit_o);
      h_busy.push_back(busy_o);
      h_valid.push_back(valid_o);
      h_err.push_back(err_o);
      h_xfer.push_back(valid_o && ready_i);
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] srcq[N][$];
  int seqn = 0;

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] v,
                      input logic [N*W-1:0] f, input logic rd);
    req_i = r; valid_i = v; flit_i = f; ready_i = rd;
    model_eval();
    @(posedge clk); #1;
    model_commit();
  endtask

  task automatic add_packet(input int i, input int len, output int first);
    first = seqn;
    if (len == 1) begin
      srcq[i].push_back(mk(T_HT, i, seqn)); seqn++;
    end else begin
      srcq[i].push_back(mk(T_HEAD, i, seqn)); seqn++;
      for (int k = 0; k < len - 2; k++) begin
        srcq[i].push_back(mk(T_BODY, i, seqn)); seqn++;
      end
      srcq[i].push_back(mk(T_TAIL, i, seqn)); seqn++;
    end
  endtask

  task automatic run_sources(input int max_cycles, input bit rnd, input logic [31:0] rpat);
    logic [N-1:0]   r, v;
    logic [N*W-1:0] f;
    logic           rd;
    logic [1:0]     t;
    bit             pending;
    for (int c = 0; c < max_cycles; c++) begin
      pending = (m_owner >= 0);
      for (int i = 0; i < N; i++) if (srcq[i].size() != 0) pending = 1;
      if (!pending) break;
      r = '0; v = '0; f = '0;
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() != 0) begin
          f = put(f, i, srcq[i][0]);
          t = srcq[i][0][W-1:W-2];
          v[i] = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
          if (opens(t)) r[i] = rnd ? ($urandom_range(0, 9) != 0) : 1'b1;
          else          r[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end else if (rnd) begin
          f = put(f, i, mk(($urandom_range(0, 1) != 0) ? T_BODY : T_TAIL, 99,
                           int'($urandom_range(0, 1000))));
          v[i] = 1'($urandom_range(0, 1));
          r[i] = 1'($urandom_range(0, 1));
        end
      end
      rd = rnd ? ($urandom_range(0, 3) != 0) : ((c < 32) ? rpat[c] : 1'b1);
      step(r, v, f, rd);
      if (xfer_src >= 0) void'(srcq[xfer_src].pop_front());
    end
    pending = (m_owner >= 0);
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) pending = 1;
    chk("drain_pending", 64'(pending), 64'(0));
  endtask

  task automatic idle_step();
    step('0, '0, '0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, s, tmp;
    logic [N*W-1:0] f, f0;
    logic [N-1:0] fair_g [6];
    fair_g = '{5'b00001, 5'b00010, 5'b10000, 5'b00001, 5'b00010, 5'b10000};

    // Reset with every input active
    arst = 1'b0;
    req_i = '1; valid_i = '1; ready_i = 1'b1;
    f = '0;
    for (int i = 0; i < N; i++) f = put(f, i, mk(T_HEAD, i, 0));
    flit_i = f;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 64'(grant_o), 64'(0));
    chk("rst_busy",  64'(busy_o),  64'(0));
    chk("rst_err",   64'(err_o),   64'(0));
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_ready", 64'(ready_o), 64'(0));
    chk("rst_flit",  64'(flit_o),  64'(0));
    arst = 1'b1;
    mon_en = 1;

    // Fairness: 0,1,4 each send two single-flit packets back to back
    b = cyc;
    for (int p = 0; p < 2; p++) begin
      add_packet(0, 1, tmp); add_packet(1, 1, tmp); add_packet(4, 1, tmp);
    end
    run_sources(100, 0, '1);
    for (int k = 0; k < 6; k++) begin
      chk("fair_grant", 64'(h_grant[b + 1 + 2*k]), 64'(fair_g[k]));
      chk("fair_gap",   64'(h_grant[b + 2 + 2*k]), 64'(0));
    end

    // Single 3-flit packet on input 2
    b = cyc;
    add_packet(2, 3, tmp);
    run_sources(50, 0, '1);
    idle_step();
    chk("single_grant_c1", 64'(h_grant[b+1]), 64'(5'b00100));
    chk("single_idle_c0",  64'(h_grant[b]),   64'(0));
    for (int k = 1; k <= 3; k++) chk("single_xfer", 64'(h_xfer[b+k]), 64'(1));
    chk("single_busy_c3", 64'(h_busy[b+3]), 64'(1));
    chk("single_busy_c4", 64'(h_busy[b+4]), 64'(0));

    // Backpressure: ready_i low for 4 cycles after the head
    b = cyc;
    add_packet(1, 4, s);
    run_sources(50, 0, 32'hFFFF_FFC3);
    idle_step();
    for (int k = 2; k <= 5; k++) begin
      chk("bp_noxfer", 64'(h_xfer[b+k]),  64'(0));
      chk("bp_flit",   64'(h_flit[b+k]),  64'(mk(T_BODY, 1, s + 1)));
      chk("bp_grant",  64'(h_grant[b+k]), 64'(5'b00010));
    end
    chk("bp_resume", 64'(h_xfer[b+6]), 64'(1));

    // Wormhole hold: input 3 valid drops for 3 cycles while input 0 requests
    b = cyc; s = seqn; seqn += 4;
    f = put('0, 3, mk(T_HEAD, 3, s));
    step(5'b01000, 5'b01000, f, 1'b1);
    f = put(f, 0, mk(T_HT, 0, s + 3));
    step(5'b01001, 5'b01001, f, 1'b1);
    f = put(put('0, 3, mk(T_BODY, 3, s + 1)), 0, mk(T_HT, 0, s + 3));
    repeat (3) step(5'b00001, 5'b00001, f, 1'b1);
    f = put(f, 3, mk(T_TAIL, 3, s + 2));
    step(5'b01001, 5'b01001, f, 1'b1);
    f0 = put('0, 0, mk(T_HT, 0, s + 3));
    step(5'b00001, 5'b00001, f0, 1'b1);
    step(5'b00001, 5'b00001, f0, 1'b1);
    idle_step();
    for (int k = 2; k <= 4; k++) begin
      chk("wh_hold_grant", 64'(h_grant[b+k]), 64'(5'b01000));
      chk("wh_hold_valid", 64'(h_valid[b+k]), 64'(0));
    end
    chk("wh_tail_xfer", 64'(h_xfer[b+5]),  64'(1));
    chk("wh_bubble",    64'(h_grant[b+6]), 64'(0));
    chk("wh_next",      64'(h_grant[b+7]), 64'(5'b00001));

    // Protocol error: second head on the locked input, then reset mid-packet
    b = cyc; s = seqn; seqn += 4;
    f = put('0, 2, mk(T_HEAD, 2, s));
    step(5'b00100, 5'b00100, f, 1'b1);
    step(5'b00100, 5'b00100, f, 1'b1);
    step(5'b00100, 5'b00100, put('0, 2, mk(T_HEAD, 2, s + 1)), 1'b1);
    step(5'b00100, 5'b00100, put('0, 2, mk(T_BODY, 2, s + 2)), 1'b1);
    step(5'b00100, 5'b00100, put('0, 2, mk(T_BODY, 2, s + 3)), 1'b1);
    chk("err_before", 64'(h_err[b+2]),  64'(0));
    chk("err_fwd",    64'(h_xfer[b+2]), 64'(1));
    chk("err_set",    64'(h_err[b+3]),  64'(1));
    chk("err_sticky", 64'(h_err[b+4]),  64'(1));
    chk("err_locked", 64'(h_busy[b+4]), 64'(1));
    mon_en = 0;
    #2;
    arst = 1'b0;
    #1;
    chk("mid_rst_grant", 64'(grant_o), 64'(0));
    chk("mid_rst_busy",  64'(busy_o),  64'(0));
    chk("mid_rst_err",   64'(err_o),   64'(0));
    chk("mid_rst_valid", 64'(valid_o), 64'(0));
    chk("mid_rst_ready", 64'(ready_o), 64'(0));
    @(posedge clk); #1;
    arst = 1'b1;
    model_reset();
    mon_en = 1;

    // Non-head flits while idle are never granted and raise no error
    b = cyc;
    f = put(put('0, 4, mk(T_BODY, 4, 7)), 3, mk(T_TAIL, 3, 8));
    repeat (3) step(5'b11000, 5'b11000, f, 1'b1);
    idle_step();
    for (int k = 0; k < 3; k++) chk("nonhead_grant", 64'(h_grant[b+k]), 64'(0));
    chk("nonhead_err", 64'(h_err[b+3]), 64'(0));

    // Randomized traffic against the model
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 25; p++) add_packet(i, int'($urandom_range(1, 5)), tmp);
    run_sources(20000, 1, '1);
    idle_step();
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
